// File: rtl/fixed_point_divider.sv
// fixed_point_divider
//
// Sequential signed fixed-point divider: Div_result = a / b for two
// Q(bitsize-FRAC_BITS).FRAC_BITS operands, returned in the widened
// (2*bitsize-FRAC_BITS)-bit Q format with FRAC_BITS fractional bits.
// Restoring radix-2 division, one quotient bit per clock, then a final
// cycle that rounds, applies the sign, saturates and registers the result.
//
// Latency: start_flag sampled at edge E0, result and valid at E(ITER+1).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_flag   division request, sampled only while busy is low
//   a, b         signed dividend / divisor
//   Div_result   signed quotient, registered, held until the next result
//   valid        one-cycle pulse when Div_result updates
//   busy         division in progress, start_flag ignored
//   div_by_zero  registered with Div_result, set when b was zero
//
// Build option:
//   FXD_DIV_ROUND_EN  defined   : round to nearest, ties away from zero
//                     undefined : truncate toward zero
module fixed_point_divider #(
  parameter int bitsize   = 14,
  parameter int FRAC_BITS = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_flag,
  input  logic [bitsize-1:0]                 a,
  input  logic [bitsize-1:0]                 b,
  output logic [2*bitsize-FRAC_BITS-1:0]     Div_result,
  output logic                               valid,
  output logic                               busy,
  output logic                               div_by_zero
);

  localparam int ITER = bitsize + FRAC_BITS;
  localparam int OW   = 2*bitsize - FRAC_BITS;
  localparam int CW   = $clog2(ITER);
  // Signed working width for sign application and saturation: wide enough
  // for the rounded magnitude plus a carry and a sign bit.
  localparam int SW   = ((ITER > OW) ? ITER : OW) + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Dividend shifts out of the top while quotient bits shift in at the
  // bottom; after ITER steps this register holds the quotient magnitude.
  logic [ITER-1:0]      dq_q, dq_d;
  logic [bitsize-1:0]   rem_q, rem_d;
  logic [bitsize-1:0]   mag_b_q, mag_b_d;
  logic                 sign_q, sign_d;
  logic                 neg_a_q, neg_a_d;
  logic                 a_zero_q, a_zero_d;
  logic                 b_zero_q, b_zero_d;
  logic [OW-1:0]        result_q, result_d;
  logic                 dbz_q, dbz_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  // Magnitudes are held unsigned: |-2^(bitsize-1)| = 2^(bitsize-1) still
  // fits in bitsize bits once the sign bit is reinterpreted as magnitude.
  logic [bitsize-1:0]   abs_a, abs_b;
  logic [bitsize:0]     rem_shift;

  logic [ITER:0]        mag_rnd;
  logic signed [SW-1:0] mag_ext;
  logic signed [SW-1:0] signed_res;
  logic signed [SW-1:0] sat_max;
  logic signed [SW-1:0] sat_min;
  logic [OW-1:0]        clamped;
  logic [OW-1:0]        fin_result;

  always_comb begin
    abs_a = a[bitsize-1] ? (~a + 1'b1) : a;
    abs_b = b[bitsize-1] ? (~b + 1'b1) : b;
  end

  // Final-cycle result: round, sign, saturate, divide-by-zero override.
  always_comb begin
    mag_rnd = {1'b0, dq_q};
`ifdef FXD_DIV_ROUND_EN
    // 2*rem >= |b| means the discarded fraction is at least one half.
    if ({rem_q, 1'b0} >= {1'b0, mag_b_q}) begin
      mag_rnd = {1'b0, dq_q} + 1'b1;
    end
`endif
    mag_ext            = '0;
    mag_ext[ITER:0]    = mag_rnd;
    // Sign is applied to the rounded magnitude so results mirror about zero.
    signed_res         = sign_q ? -mag_ext : mag_ext;

    sat_max            = '0;
    sat_max[OW-2:0]    = '1;
    sat_min            = '1;
    sat_min[OW-2:0]    = '0;

    // Checked after rounding because the rounding carry can overflow.
    if (signed_res > sat_max) begin
      clamped = sat_max[OW-1:0];
    end else if (signed_res < sat_min) begin
      clamped = sat_min[OW-1:0];
    end else begin
      clamped = signed_res[OW-1:0];
    end

    if (b_zero_q) begin
      if (a_zero_q) begin
        fin_result = '0;
      end else if (neg_a_q) begin
        fin_result = sat_min[OW-1:0];
      end else begin
        fin_result = sat_max[OW-1:0];
      end
    end else begin
      fin_result = clamped;
    end
  end

  // NOTE: every signal is given a default at the top of the block so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    mag_b_d   = mag_b_q;
    sign_d    = sign_q;
    neg_a_d   = neg_a_q;
    a_zero_d  = a_zero_q;
    b_zero_d  = b_zero_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    rem_shift = {rem_q, dq_q[ITER-1]};

    unique case (state_q)
      S_IDLE: begin
        if (start_flag) begin
          state_d  = S_DIV;
          cnt_d    = CW'(ITER - 1);
          dq_d     = {abs_a, {FRAC_BITS{1'b0}}};
          rem_d    = '0;
          mag_b_d  = abs_b;
          sign_d   = a[bitsize-1] ^ b[bitsize-1];
          neg_a_d  = a[bitsize-1];
          a_zero_d = (a == '0);
          b_zero_d = (b == '0);
          busy_d   = 1'b1;
        end
      end

      S_DIV: begin
        // A successful subtraction leaves rem < |b|, so the low bits of the
        // difference are the whole new remainder.
        if (rem_shift >= {1'b0, mag_b_q}) begin
          rem_d = rem_shift[bitsize-1:0] - mag_b_q;
          dq_d  = {dq_q[ITER-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[bitsize-1:0];
          dq_d  = {dq_q[ITER-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIN: begin
        result_d = fin_result;
        dbz_d    = b_zero_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      mag_b_q  <= '0;
      sign_q   <= 1'b0;
      neg_a_q  <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      mag_b_q  <= mag_b_d;
      sign_q   <= sign_d;
      neg_a_q  <= neg_a_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign Div_result  = result_q;
  assign div_by_zero = dbz_q;
  assign valid       = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed testbench for fixed_point_divider (bitsize=14, FRAC_BITS=7).
// Expected quotients are raw Q7 integers worked out by hand; rounding
// expectations follow the FXD_DIV_ROUND_EN build option.
module tb_fixed_point_divider;

  localparam int BITSIZE = 14;
  localparam int FRAC    = 7;
  localparam int OW      = 2*BITSIZE - FRAC;
  localparam int LAT     = BITSIZE + FRAC + 1;

`ifdef FXD_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start_flag;
  logic [BITSIZE-1:0]  a;
  logic [BITSIZE-1:0]  b;
  logic [OW-1:0]       Div_result;
  logic                valid;
  logic                busy;
  logic                div_by_zero;

  int checks = 0;
  int errors = 0;

  fixed_point_divider #(
    .bitsize   (BITSIZE),
    .FRAC_BITS (FRAC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_flag  (start_flag),
    .a           (a),
    .b           (b),
    .Div_result  (Div_result),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Issue one division and follow it to its valid pulse. Returns in the
  // valid cycle (1 time unit after the edge that raised valid), so a caller
  // may start the next division immediately. glitch_at >= 0 pulses
  // start_flag with different operands at that cycle of the division.
  task automatic run_div(input string tag, input int av, input int bv,
                         input int exp_res, input bit exp_dbz, input int glitch_at);
    int n;
    int busy_hi;
    a          = BITSIZE'(av);
    b          = BITSIZE'(bv);
    start_flag = 1'b1;
    @(posedge clk); #1;
    start_flag = 1'b0;
    n       = 0;
    busy_hi = 0;
    while (valid !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_hi++;
      if (n == glitch_at) begin
        start_flag = 1'b1;
        a          = BITSIZE'(1);
        b          = BITSIZE'(1);
      end
      @(posedge clk); #1;
      start_flag = 1'b0;
      n++;
    end
    check({tag, "_latency"},   n,                   LAT);
    check({tag, "_busy_hi"},   busy_hi,             LAT);
    check({tag, "_result"},    $signed(Div_result), exp_res);
    check({tag, "_dbz"},       div_by_zero,         exp_dbz);
    check({tag, "_busy_low"},  busy,                0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst        = 1'b0;
    start_flag = 1'b0;
    a          = '0;
    b          = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_result", Div_result,  0);
    check("reset_valid",  valid,       0);
    check("reset_busy",   busy,        0);
    check("reset_dbz",    div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1.5 / 0.5 = 3.0 -> 384; valid must be one cycle and the result held.
    run_div("exact", 192, 64, 384, 1'b0, -1);
    @(posedge clk); #1;
    check("exact_valid_width", valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("exact_hold", $signed(Div_result), 384);

    // 16384/384 = 42.67
    run_div("round_pos", 128, 384, ROUND ? 43 : 42, 1'b0, -1);
    @(posedge clk); #1;
    run_div("round_neg", -128, 384, ROUND ? -43 : -42, 1'b0, -1);
    @(posedge clk); #1;
    // 128/256 = 0.5 exactly: tie goes away from zero
    run_div("tie", 1, 256, ROUND ? 1 : 0, 1'b0, -1);
    @(posedge clk); #1;
    run_div("min_by_one", -8192, 1, -1048576, 1'b0, -1);
    @(posedge clk); #1;
    run_div("min_by_neg1_sat", -8192, -1, 1048575, 1'b0, -1);
    @(posedge clk); #1;

    run_div("dbz_pos", 100, 0, 1048575, 1'b1, -1);
    @(posedge clk); #1;
    run_div("dbz_zero", 0, 0, 0, 1'b1, -1);
    @(posedge clk); #1;
    run_div("dbz_neg", -5, 0, -1048576, 1'b1, -1);
    @(posedge clk); #1;

    // Reset ten cycles into a division: outputs clear, no valid afterwards.
    a          = BITSIZE'(192);
    b          = BITSIZE'(64);
    start_flag = 1'b1;
    @(posedge clk); #1;
    start_flag = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_result", Div_result,  0);
    check("midrst_dbz",    div_by_zero, 0);
    check("midrst_busy",   busy,        0);
    check("midrst_valid",  valid,       0);
    @(posedge clk); #1;
    rst    = 1'b0;
    vcount = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid === 1'b1) vcount++;
    end
    check("midrst_no_valid", vcount, 0);

    // start_flag pulsed mid-division must be ignored.
    run_div("glitch", 192, 64, 384, 1'b0, 5);
    @(posedge clk); #1;

    // Back-to-back: the second start is raised during the first valid cycle.
    run_div("b2b_first",  128, 384, ROUND ? 43 : 42, 1'b0, -1);
    run_div("b2b_second", -128, 384, ROUND ? -43 : -42, 1'b0, -1);
    @(posedge clk); #1;
    check("b2b_valid_width", valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
